// File: rtl/core_bus_master_if.sv
// -----------------------------------------------------------------------------
// core_bus_master_if
// Avalon-MM master/slave bundle used by core_bus_master.
//   address       byte address (master -> slave)
//   read / write  command strobes (master -> slave)
//   writedata     write data (master -> slave)
//   byteenable    byte lane enables (master -> slave)
//   waitrequest   slave stall; command accepted when low (slave -> master)
//   readdata      read data (slave -> master)
//   readdatavalid readdata qualifier (slave -> master)
//   response      2'b00 = OK, anything else is an error (slave -> master)
// -----------------------------------------------------------------------------
interface core_bus_master_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [1:0]  response;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid, response
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, response
    );
endinterface

// File: rtl/core_bus_master.sv
// -----------------------------------------------------------------------------
// core_bus_master
// Bridges a simple pulse-based core request port onto an Avalon-MM master.
// One transaction is in flight at a time; one further request can be queued
// in a single-entry pending buffer and is issued straight after the current
// transaction's DONE cycle. Any further request is dropped and flagged.
//
// Ports
//   clk, rst_n   core clock, asynchronous active-low reset
//   bus_addr     word address of the request
//   bus_start    one-cycle request pulse
//   bus_write    1 = write, 0 = read
//   bus_data_wr  write data
//   bus_data_be  byte enables
//   bus_ready    one-cycle completion pulse
//   bus_data_rd  data of the most recent completed read
//   bus_error    sticky error (dropped request or non-OK response)
//   error_clear  clears bus_error (a simultaneous new error wins)
//   avl          Avalon-MM master side
// -----------------------------------------------------------------------------
module core_bus_master (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [29:0]              bus_addr,
    input  logic                     bus_start,
    input  logic                     bus_write,
    input  logic [31:0]              bus_data_wr,
    input  logic [3:0]               bus_data_be,
    output logic                     bus_ready,
    output logic [31:0]              bus_data_rd,
    output logic                     bus_error,
    input  logic                     error_clear,
    core_bus_master_if.master        avl
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state, state_next;

    // Decoded per-cycle events
    logic        cmd_accept;   // command taken by the slave this edge
    logic        rd_done;      // read data captured this edge
    logic        issue_new;    // issue the request on the core port now
    logic        issue_pend;   // issue the buffered request now
    logic        store_pend;   // park the core request in the buffer
    logic        drop_req;     // buffer full, request lost
    logic        err_set;

    // Direction of the transaction currently on the bus
    logic        cur_write;

    // Single-entry pending buffer
    logic        pend_valid;
    logic        pend_write;
    logic [29:0] pend_addr;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_be;

    // -------------------------------------------------------------------------
    // Next-state and event decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next = state;
        cmd_accept = 1'b0;
        rd_done    = 1'b0;
        issue_new  = 1'b0;
        issue_pend = 1'b0;
        store_pend = 1'b0;
        drop_req   = 1'b0;
        err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (bus_start) begin
                    issue_new  = 1'b1;
                    state_next = CMD;
                end
            end

            CMD: begin
                if (bus_start) begin
                    drop_req   = pend_valid;
                    store_pend = !pend_valid;
                end
                if (!avl.waitrequest) begin
                    cmd_accept = 1'b1;
                    if (cur_write) begin
                        state_next = DONE;
                        err_set    = (avl.response != 2'b00);
                    end else if (avl.readdatavalid) begin
                        // Data returned in the acceptance cycle itself
                        rd_done    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RDWAIT;
                    end
                end
            end

            RDWAIT: begin
                if (bus_start) begin
                    drop_req   = pend_valid;
                    store_pend = !pend_valid;
                end
                if (avl.readdatavalid) begin
                    rd_done    = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (pend_valid) begin
                    // Buffer is still occupied during this cycle, so a new
                    // request here has nowhere to go.
                    issue_pend = 1'b1;
                    drop_req   = bus_start;
                    state_next = CMD;
                end else if (bus_start) begin
                    // Equivalent to buffering it and issuing next cycle
                    issue_new  = 1'b1;
                    state_next = CMD;
                end else begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        if (rd_done && avl.response != 2'b00) err_set = 1'b1;
        if (drop_req)                          err_set = 1'b1;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Registered Avalon command, completion, read data, error and buffer flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avl.read       <= 1'b0;
            avl.write      <= 1'b0;
            avl.address    <= '0;
            avl.writedata  <= '0;
            avl.byteenable <= '0;
            cur_write      <= 1'b0;
            bus_ready      <= 1'b0;
            bus_data_rd    <= '0;
            bus_error      <= 1'b0;
            pend_valid     <= 1'b0;
        end else begin
            if (issue_new) begin
                avl.read       <= !bus_write;
                avl.write      <= bus_write;
                avl.address    <= {bus_addr, 2'b00};
                avl.writedata  <= bus_data_wr;
                avl.byteenable <= bus_data_be;
                cur_write      <= bus_write;
            end else if (issue_pend) begin
                avl.read       <= !pend_write;
                avl.write      <= pend_write;
                avl.address    <= {pend_addr, 2'b00};
                avl.writedata  <= pend_wdata;
                avl.byteenable <= pend_be;
                cur_write      <= pend_write;
            end else if (cmd_accept) begin
                // Fields stay put; only the strobes drop
                avl.read       <= 1'b0;
                avl.write      <= 1'b0;
            end

            // DONE never follows itself, so this is a single-cycle pulse
            bus_ready <= (state_next == DONE);

            if (rd_done) bus_data_rd <= avl.readdata;

            if (err_set)          bus_error <= 1'b1;
            else if (error_clear) bus_error <= 1'b0;

            if (store_pend)      pend_valid <= 1'b1;
            else if (issue_pend) pend_valid <= 1'b0;
        end
    end

    // NOTE: buffer payload has no reset; it is only ever read while
    // pend_valid (which is reset) says it holds a captured request.
    always_ff @(posedge clk) begin
        if (store_pend) begin
            pend_write <= bus_write;
            pend_addr  <= bus_addr;
            pend_wdata <= bus_data_wr;
            pend_be    <= bus_data_be;
        end
    end

endmodule

// File: tb/tb_core_bus_master.sv
// -----------------------------------------------------------------------------
// tb_core_bus_master
// Directed bench for core_bus_master. Expected Avalon commands and expected
// completions are queued when a request is driven; a negedge monitor pops
// and compares them when the DUT accepts a command or pulses bus_ready.
// -----------------------------------------------------------------------------
module tb_core_bus_master;

    logic        clk;
    logic        rst_n;
    logic [29:0] bus_addr;
    logic        bus_start;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_data_be;
    logic        bus_ready;
    logic [31:0] bus_data_rd;
    logic        bus_error;
    logic        error_clear;

    core_bus_master_if avl ();

    core_bus_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_addr    (bus_addr),
        .bus_start   (bus_start),
        .bus_write   (bus_write),
        .bus_data_wr (bus_data_wr),
        .bus_data_be (bus_data_be),
        .bus_ready   (bus_ready),
        .bus_data_rd (bus_data_rd),
        .bus_error   (bus_error),
        .error_clear (error_clear),
        .avl         (avl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    txn_t cmd_q[$];   // expected Avalon commands, in issue order
    txn_t exp_q[$];   // expected completions, in completion order

    int n_checks  = 0;
    int n_errors  = 0;
    int ready_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus_start pulse; queue expectations if the request should run
    task automatic pulse_start(input logic wr, input logic [29:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] rdata, input bit expect_run);
        txn_t t;
        t.write = wr; t.addr = addr; t.wdata = wdata; t.be = be; t.rdata = rdata;
        if (expect_run) begin
            cmd_q.push_back(t);
            exp_q.push_back(t);
        end
        bus_start   = 1'b1;
        bus_write   = wr;
        bus_addr    = addr;
        bus_data_wr = wdata;
        bus_data_be = be;
        step();
        bus_start   = 1'b0;
    endtask

    // Monitor: compares accepted commands and completions against the queues
    always @(negedge clk) begin
        txn_t t;
        if (avl.read || avl.write) begin
            check("rw_exclusive", {31'b0, avl.read & avl.write}, 32'd0);
            if (!avl.waitrequest) begin
                check("cmd_expected", {31'b0, cmd_q.size() != 0}, 32'd1);
                if (cmd_q.size() != 0) begin
                    t = cmd_q.pop_front();
                    check("cmd_address", avl.address, {t.addr, 2'b00});
                    check("cmd_write", {31'b0, avl.write}, {31'b0, t.write});
                    if (t.write) begin
                        check("cmd_writedata", avl.writedata, t.wdata);
                        check("cmd_byteenable", {28'b0, avl.byteenable}, {28'b0, t.be});
                    end
                end
            end
        end
        if (bus_ready) begin
            ready_cnt++;
            check("ready_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                if (!t.write) check("read_data", bus_data_rd, t.rdata);
            end
        end
    end

    int ready_base;

    initial begin
        rst_n             = 1'b0;
        bus_addr          = '0;
        bus_start         = 1'b0;
        bus_write         = 1'b0;
        bus_data_wr       = '0;
        bus_data_be       = '0;
        error_clear       = 1'b0;
        avl.waitrequest   = 1'b0;
        avl.readdata      = '0;
        avl.readdatavalid = 1'b0;
        avl.response      = 2'b00;

        // ---------------- Reset state ----------------
        step(); step();
        check("rst_read", {31'b0, avl.read}, 32'd0);
        check("rst_write", {31'b0, avl.write}, 32'd0);
        check("rst_address", avl.address, 32'd0);
        check("rst_ready", {31'b0, bus_ready}, 32'd0);
        check("rst_data_rd", bus_data_rd, 32'd0);
        check("rst_error", {31'b0, bus_error}, 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- Read, zero wait ----------------
        pulse_start(1'b0, 30'h0000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        check("rd0_read_issued", {31'b0, avl.read}, 32'd1);
        check("rd0_address", avl.address, 32'h0000_0010);
        check("rd0_no_write", {31'b0, avl.write}, 32'd0);
        step();
        check("rd0_read_dropped", {31'b0, avl.read}, 32'd0);
        check("rd0_no_ready_yet", {31'b0, bus_ready}, 32'd0);
        avl.readdatavalid = 1'b1;
        avl.readdata      = 32'hDEAD_BEEF;
        step();
        avl.readdatavalid = 1'b0;
        check("rd0_ready", {31'b0, bus_ready}, 32'd1);
        check("rd0_data", bus_data_rd, 32'hDEAD_BEEF);
        step();
        check("rd0_ready_one_cycle", {31'b0, bus_ready}, 32'd0);

        // ---------------- Write with 3-cycle stall ----------------
        avl.waitrequest = 1'b1;
        pulse_start(1'b1, 30'h0000_0100, 32'h1234_5678, 4'b0011, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("wr_stall_write_held", {31'b0, avl.write}, 32'd1);
            check("wr_stall_address", avl.address, 32'h0000_0400);
            check("wr_stall_wdata", avl.writedata, 32'h1234_5678);
            check("wr_stall_be", {28'b0, avl.byteenable}, 32'h3);
            check("wr_stall_no_ready", {31'b0, bus_ready}, 32'd0);
            if (i == 3) avl.waitrequest = 1'b0;
            step();
        end
        check("wr_write_dropped", {31'b0, avl.write}, 32'd0);
        check("wr_ready", {31'b0, bus_ready}, 32'd1);
        check("wr_data_rd_held", bus_data_rd, 32'hDEAD_BEEF);
        step();
        check("wr_ready_one_cycle", {31'b0, bus_ready}, 32'd0);

        // ---------------- Back-to-back reads ----------------
        ready_base = ready_cnt;
        pulse_start(1'b0, 30'h0000_0008, 32'h0, 4'h0, 32'hA5A5_0001, 1'b1);
        step();                                             // accepted, RDWAIT
        pulse_start(1'b0, 30'h0000_000C, 32'h0, 4'h0, 32'h0000_0002, 1'b1);
        check("b2b_buffered_no_issue", {31'b0, avl.read}, 32'd0);
        avl.readdatavalid = 1'b1;
        avl.readdata      = 32'hA5A5_0001;
        step();
        avl.readdatavalid = 1'b0;
        check("b2b_first_ready", {31'b0, bus_ready}, 32'd1);
        check("b2b_first_data", bus_data_rd, 32'hA5A5_0001);
        check("b2b_no_issue_in_done", {31'b0, avl.read}, 32'd0);
        step();
        check("b2b_second_issued", {31'b0, avl.read}, 32'd1);
        check("b2b_second_address", avl.address, 32'h0000_0030);
        check("b2b_ready_low", {31'b0, bus_ready}, 32'd0);
        // Data valid in the acceptance cycle
        avl.readdatavalid = 1'b1;
        avl.readdata      = 32'h0000_0002;
        step();
        avl.readdatavalid = 1'b0;
        check("b2b_second_ready", {31'b0, bus_ready}, 32'd1);
        check("b2b_second_data", bus_data_rd, 32'h0000_0002);
        check("b2b_read_low", {31'b0, avl.read}, 32'd0);
        step();
        check("b2b_ready_count", ready_cnt - ready_base, 32'd2);
        check("b2b_no_error", {31'b0, bus_error}, 32'd0);

        // ---------------- Overflow ----------------
        ready_base      = ready_cnt;
        avl.waitrequest = 1'b1;
        pulse_start(1'b1, 30'h0000_0020, 32'h1111_1111, 4'hF, 32'h0, 1'b1);
        check("ovf_first_address", avl.address, 32'h0000_0080);
        pulse_start(1'b1, 30'h0000_0021, 32'h2222_2222, 4'h5, 32'h0, 1'b1);
        check("ovf_no_error_yet", {31'b0, bus_error}, 32'd0);
        pulse_start(1'b1, 30'h0000_0022, 32'h3333_3333, 4'hA, 32'h0, 1'b0);
        check("ovf_error_set", {31'b0, bus_error}, 32'd1);
        check("ovf_cmd_stable", avl.writedata, 32'h1111_1111);
        avl.waitrequest = 1'b0;
        step();
        check("ovf_first_ready", {31'b0, bus_ready}, 32'd1);
        step();
        check("ovf_second_issued", {31'b0, avl.write}, 32'd1);
        check("ovf_second_address", avl.address, 32'h0000_0084);
        check("ovf_second_wdata", avl.writedata, 32'h2222_2222);
        step();
        check("ovf_second_ready", {31'b0, bus_ready}, 32'd1);
        step();
        step();
        check("ovf_idle_no_write", {31'b0, avl.write}, 32'd0);
        check("ovf_ready_count", ready_cnt - ready_base, 32'd2);
        check("ovf_error_sticky", {31'b0, bus_error}, 32'd1);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        check("ovf_error_cleared", {31'b0, bus_error}, 32'd0);

        // ---------------- Read error response ----------------
        pulse_start(1'b0, 30'h0000_0010, 32'h0, 4'h0, 32'hBAD0_0BAD, 1'b1);
        step();
        avl.readdatavalid = 1'b1;
        avl.readdata      = 32'hBAD0_0BAD;
        avl.response      = 2'b10;
        step();
        avl.readdatavalid = 1'b0;
        avl.response      = 2'b00;
        check("rderr_ready", {31'b0, bus_ready}, 32'd1);
        check("rderr_error", {31'b0, bus_error}, 32'd1);
        check("rderr_data_forwarded", bus_data_rd, 32'hBAD0_0BAD);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        check("rderr_cleared", {31'b0, bus_error}, 32'd0);

        // ---------------- Write error with simultaneous clear ----------------
        pulse_start(1'b1, 30'h0000_0014, 32'hCAFE_F00D, 4'hC, 32'h0, 1'b1);
        avl.response = 2'b01;
        error_clear  = 1'b1;
        step();
        avl.response = 2'b00;
        error_clear  = 1'b0;
        check("wrerr_ready", {31'b0, bus_ready}, 32'd1);
        check("wrerr_set_wins", {31'b0, bus_error}, 32'd1);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        check("wrerr_cleared", {31'b0, bus_error}, 32'd0);

        // ---------------- Reset during RDWAIT ----------------
        ready_base = ready_cnt;
        pulse_start(1'b0, 30'h0000_0018, 32'h0, 4'h0, 32'h0, 1'b1);
        step();                                             // accepted, RDWAIT
        rst_n = 1'b0;
        #1;
        exp_q.delete();                                     // abandoned read
        check("mrst_read", {31'b0, avl.read}, 32'd0);
        check("mrst_write", {31'b0, avl.write}, 32'd0);
        check("mrst_address", avl.address, 32'd0);
        check("mrst_writedata", avl.writedata, 32'd0);
        check("mrst_byteenable", {28'b0, avl.byteenable}, 32'd0);
        check("mrst_ready", {31'b0, bus_ready}, 32'd0);
        check("mrst_data_rd", bus_data_rd, 32'd0);
        check("mrst_error", {31'b0, bus_error}, 32'd0);
        step();
        rst_n = 1'b1;
        avl.readdatavalid = 1'b1;
        avl.readdata      = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stray_rdv_no_ready", {31'b0, bus_ready}, 32'd0);
            check("stray_rdv_data_rd", bus_data_rd, 32'd0);
            check("stray_rdv_no_read", {31'b0, avl.read}, 32'd0);
        end
        avl.readdatavalid = 1'b0;
        step();
        check("mrst_ready_count", ready_cnt - ready_base, 32'd0);

        // ---------------- Scoreboard drained ----------------
        check("cmd_q_drained", cmd_q.size(), 32'd0);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_bus_master.md
CORE_BUS_MASTER -- requirements
Module: core_bus_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other ports are listed below.
REQ-002 Port: clk  in  1  core clock, all state rises on posedge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Core-side ports: bus_addr in 30 word address; bus_start in 1 request pulse; bus_write in 1 1=write; bus_data_wr in 32 write data; bus_data_be in 4 byte enables; bus_ready out 1 completion pulse; bus_data_rd out 32 read data.
REQ-005 Avalon-side ports: avl_address out 32 byte address; avl_read out 1; avl_write out 1; avl_writedata out 32; avl_byteenable out 4; avl_waitrequest in 1; avl_readdata in 32; avl_readdatavalid in 1; avl_response in 2 (0=OK).
REQ-006 Status ports: bus_error out 1 sticky error flag; error_clear in 1 clears bus_error.

Function
REQ-007 Request capture: bus_start high at a posedge latches bus_addr, bus_write, bus_data_wr, bus_data_be; bus_start is a one-cycle pulse per request.
REQ-008 avl_address SHALL equal {latched bus_addr, 2'b00}; avl_writedata/avl_byteenable SHALL equal latched values; all Avalon outputs are registered.
REQ-009 FSM states: IDLE, CMD, RDWAIT, DONE.
REQ-010 IDLE -> CMD on capture; avl_read or avl_write asserts the cycle after bus_start (1-cycle issue latency).
REQ-011 CMD: command held stable while avl_waitrequest=1; on avl_waitrequest=0 the command is accepted, avl_read/avl_write deassert next cycle.
REQ-012 CMD accepted write -> DONE; accepted read -> RDWAIT.
REQ-013 RDWAIT: on avl_readdatavalid=1, avl_readdata registered into bus_data_rd, go DONE; readdatavalid in the same cycle as acceptance SHALL also be honoured (go directly DONE).
REQ-014 DONE: bus_ready high for exactly one cycle, then IDLE (or CMD if a pending request exists, REQ-016).
REQ-015 bus_data_rd SHALL hold its last read value until the next read completes; undefined-free (reset value 0) for writes.
REQ-016 Pending buffer: one entry; bus_start while not IDLE, or in the DONE cycle, stores the request; it is issued in the cycle after DONE with no IDLE bubble.
REQ-017 bus_start while pending buffer full SHALL be dropped and SHALL set bus_error.
REQ-018 avl_response != 0 at readdatavalid (reads) or at acceptance (writes) SHALL set bus_error; transaction still completes with bus_ready; read data still forwarded.
REQ-019 bus_error is sticky until error_clear=1; error set and clear in the same cycle -> set wins.
REQ-020 avl_read and avl_write SHALL never be high simultaneously; never high outside CMD.
REQ-021 No timeout: the block waits indefinitely on waitrequest/readdatavalid.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, avl_read=0, avl_write=0, avl_address=0, avl_writedata=0, avl_byteenable=0, bus_ready=0, bus_data_rd=0, bus_error=0, pending buffer empty.
REQ-023 Reset mid-transaction SHALL abandon it without issuing bus_ready; a late avl_readdatavalid after reset release while IDLE SHALL be ignored.
REQ-024 Latched request fields need no reset beyond REQ-022 outputs.

Verification
REQ-025 Read, zero wait: bus_addr=0x0000_0004 pulse start; waitrequest=0, readdatavalid 2 cycles later with 0xDEADBEEF -> avl_address=0x10, bus_ready pulse, bus_data_rd=0xDEADBEEF.
REQ-026 Write with stall: write 0x12345678, be=4'b0011, waitrequest=1 for 3 cycles -> avl_write held 4 cycles with stable fields, bus_ready 1 cycle after acceptance.
REQ-027 Back-to-back: second start during RDWAIT of first -> second issued the cycle after first bus_ready, two bus_ready pulses, bus_error=0.
REQ-028 Overflow: three starts while first stalled -> third dropped, bus_error=1, exactly two bus_ready pulses; error_clear -> bus_error=0.
REQ-029 Error response: read with avl_response=2'b10 -> bus_ready pulses, bus_error=1.
REQ-030 Reset mid-read in RDWAIT -> all outputs 0 immediately, no bus_ready, subsequent stray readdatavalid ignored.
